// File: rtl/iterative_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package iterative_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIXUP,
        DONE
    } div_state_t;

    typedef struct packed {
        logic div_by_zero;
        logic overflow;
    } div_flags_t;

    // Cycles from acceptance to out_is_valid on the full-latency path.
    function automatic int unsigned div_latency(input int unsigned width,
                                                input int unsigned bits_per_cycle);
        return width / bits_per_cycle + 2;
    endfunction

endpackage

// File: rtl/iterative_divider_div_step.sv
// One restoring-division step: shift a dividend bit into the partial remainder and
// subtract the divisor when it fits.
module iterative_divider_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0] rem_in,
    input  logic           dividend_bit,
    input  logic [WIDTH:0] divisor,
    output logic [WIDTH:0] rem_out,
    output logic           quot_bit
);

    logic [WIDTH+1:0] diff;

    // rem_in < divisor always holds, so the shifted value fits WIDTH+1 bits and
    // diff[WIDTH+1] is a clean borrow.
    always_comb begin
        diff     = {rem_in, dividend_bit} - {1'b0, divisor};
        quot_bit = ~diff[WIDTH+1];
        rem_out  = quot_bit ? diff[WIDTH:0] : {rem_in[WIDTH-1:0], dividend_bit};
    end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring integer divider retiring BITS_PER_CYCLE quotient bits per clock.
// Optional build macro: DIVIDER_EARLY_OUT_EN (trivial operations go straight to DONE).
module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_is_valid,
    output logic             in_hold,
    input  logic [WIDTH-1:0] numer,
    input  logic [WIDTH-1:0] denom,
    input  logic             is_signed,
    output logic             out_is_valid,
    input  logic             out_hold,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned STEPS = div_latency(WIDTH, BITS_PER_CYCLE) - 2;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dq;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   dvsr;
    logic             q_neg;
    logic             r_neg;
    div_flags_t       flags_pend;

    logic [WIDTH-1:0] numer_mag;
    logic [WIDTH-1:0] denom_mag;
    logic             denom_zero;
    logic             min_by_neg1;
    div_flags_t       flags_in;

    always_comb begin
        numer_mag            = (is_signed && numer[WIDTH-1]) ? -numer : numer;
        denom_mag            = (is_signed && denom[WIDTH-1]) ? -denom : denom;
        denom_zero           = (denom == '0);
        min_by_neg1          = is_signed && (numer == {1'b1, {(WIDTH-1){1'b0}}}) && (denom == '1);
        flags_in.div_by_zero = denom_zero;
        flags_in.overflow    = denom_zero || min_by_neg1;
    end

    always_comb begin
        in_hold = in_is_valid && !(state == DONE && !out_hold);
    end

    // dq starts as the dividend magnitude; quotient bits shift in behind the consumed bits.
    logic [WIDTH:0]            rem_chain [BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] q_bits;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        if (i == 0) begin : g_first
            iterative_divider_div_step #(.WIDTH(WIDTH)) u_div_step (
                .rem_in       (rem),
                .dividend_bit (dq[WIDTH-1]),
                .divisor      (dvsr),
                .rem_out      (rem_chain[0]),
                .quot_bit     (q_bits[BITS_PER_CYCLE-1])
            );
        end else begin : g_next
            iterative_divider_div_step #(.WIDTH(WIDTH)) u_div_step (
                .rem_in       (rem_chain[i-1]),
                .dividend_bit (dq[WIDTH-1-i]),
                .divisor      (dvsr),
                .rem_out      (rem_chain[i]),
                .quot_bit     (q_bits[BITS_PER_CYCLE-1-i])
            );
        end
    end

`ifdef DIVIDER_EARLY_OUT_EN
    logic early_out;

    always_comb begin
        early_out = denom_zero || min_by_neg1 || ({1'b0, numer_mag} < {1'b0, denom_mag});
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            count        <= '0;
            dq           <= '0;
            rem          <= '0;
            dvsr         <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            flags_pend   <= '0;
            out_is_valid <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            div_by_zero  <= 1'b0;
            overflow     <= 1'b0;
        end else if (flush) begin
            state        <= IDLE;
            out_is_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_is_valid) begin
                        dq         <= numer_mag;
                        rem        <= '0;
                        dvsr       <= {1'b0, denom_mag};
                        q_neg      <= is_signed && (numer[WIDTH-1] ^ denom[WIDTH-1]);
                        r_neg      <= is_signed && numer[WIDTH-1];
                        flags_pend <= flags_in;
                        count      <= CW'(STEPS - 1);
`ifdef DIVIDER_EARLY_OUT_EN
                        if (early_out) begin
                            quotient     <= denom_zero ? '1 : (min_by_neg1 ? numer : '0);
                            remainder    <= min_by_neg1 ? '0 : numer;
                            div_by_zero  <= flags_in.div_by_zero;
                            overflow     <= flags_in.overflow;
                            out_is_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    rem   <= rem_chain[BITS_PER_CYCLE-1];
                    dq    <= {dq[WIDTH-1-BITS_PER_CYCLE:0], q_bits};
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    // A zero divisor yields all-ones quotient bits, but sign fixup must not touch them.
                    quotient     <= flags_pend.div_by_zero ? '1 : (q_neg ? -dq : dq);
                    remainder    <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    div_by_zero  <= flags_pend.div_by_zero;
                    overflow     <= flags_pend.overflow;
                    out_is_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (!out_hold) begin
                        out_is_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
